// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the aes stream controller
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 256;

  localparam logic [1:0] KEY128 = 2'd0;
  localparam logic [1:0] KEY192 = 2'd1;
  localparam logic [1:0] KEY256 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KSTART,
    ST_KWAIT,
    ST_RUN,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/aes_stream_ctrl_fifo.sv
// rtl/aes_stream_ctrl_fifo.sv - first-word fall-through synchronous fifo with occupancy count
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a push into a full fifo is still legal when a pop frees the slot in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - credit-based block issue controller in front of an aes core
module aes_stream_ctrl
  import aes_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_W-1:0]   cfg_key,
  input  logic [1:0]         cfg_key_mode,
  input  logic               cfg_ende,
  input  logic               cfg_load,
  input  logic [BLOCK_W-1:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [BLOCK_W-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               aes_start,
  output logic               aes_enable,
  output logic               aes_ende,
  output logic [1:0]         aes_key_mode,
  output logic [KEY_W-1:0]   aes_key,
  output logic [BLOCK_W-1:0] aes_data,
  output logic               aes_data_valid,
  input  logic               aes_ready,
  input  logic [BLOCK_W-1:0] aes_out_data,
  input  logic               aes_out_valid,
  input  logic               aes_key_ready,
  output logic               key_ok,
  output logic               err_overflow
);

  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;

  state_t             state;
  logic               kw_first;
  logic               outstanding;
  logic               issue_q;
  logic               cap_valid;
  logic [BLOCK_W-1:0] cap_data;
  logic [KEY_W-1:0]   sh_key;
  logic [1:0]         sh_mode;
  logic               sh_ende;

  logic [BLOCK_W-1:0] in_head;
  logic               in_empty;
  logic [ICW-1:0]     in_count;
  logic [BLOCK_W-1:0] out_head;
  logic               out_empty;
  logic [OCW-1:0]     out_count;

  logic               out_full;
  logic               out_pop;
  logic               res_hit;
  logic [OCW:0]       credit_sum;
  logic               issue;

  assign s_ready  = (in_count != ICW'(IN_DEPTH));
  assign m_valid  = !out_empty;
  assign m_data   = out_empty ? '0 : out_head;
  assign out_pop  = m_valid && m_ready;
  assign out_full = (out_count == OCW'(OUT_DEPTH));
  assign res_hit  = aes_out_valid && outstanding;

  // the captured result is not yet in out_count, so it must consume a credit too
  assign credit_sum = {1'b0, out_count} + {{OCW{1'b0}}, cap_valid} + {{OCW{1'b0}}, outstanding};
  assign issue = (state == ST_RUN) && !in_empty && aes_ready && !outstanding
                 && (credit_sum < (OCW+1)'(OUT_DEPTH));

  sync_fifo #(.WIDTH(BLOCK_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s_valid && s_ready),
    .push_data (s_data),
    .pop       (issue),
    .head      (in_head),
    .empty     (in_empty),
    .count     (in_count)
  );

  sync_fifo #(.WIDTH(BLOCK_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cap_valid),
    .push_data (cap_data),
    .pop       (out_pop),
    .head      (out_head),
    .empty     (out_empty),
    .count     (out_count)
  );

  // block issue, result capture, in-flight tracking and the sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aes_enable     <= 1'b0;
      aes_data       <= '0;
      aes_data_valid <= 1'b0;
      issue_q        <= 1'b0;
      cap_valid      <= 1'b0;
      cap_data       <= '0;
      outstanding    <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      aes_enable     <= 1'b1;
      issue_q        <= issue;
      aes_data_valid <= issue_q;
      if (issue) aes_data <= in_head;
      cap_valid <= res_hit;
      if (res_hit) cap_data <= aes_out_data;
      if (issue && !res_hit)      outstanding <= 1'b1;
      else if (res_hit && !issue) outstanding <= 1'b0;
      if ((aes_out_valid && !outstanding) || (cap_valid && out_full && !out_pop))
        err_overflow <= 1'b1;
    end
  end

  // key-load sequencing; core config outputs change only when nothing is in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      key_ok       <= 1'b0;
      aes_start    <= 1'b0;
      kw_first     <= 1'b0;
      sh_key       <= '0;
      sh_mode      <= '0;
      sh_ende      <= 1'b0;
      aes_key      <= '0;
      aes_key_mode <= '0;
      aes_ende     <= 1'b0;
    end else begin
      aes_start <= 1'b0;
      if (cfg_load) begin
        sh_key  <= cfg_key;
        sh_mode <= cfg_key_mode;
        sh_ende <= cfg_ende;
      end
      case (state)
        ST_IDLE: begin
          key_ok <= 1'b0;
          if (cfg_load) begin
            aes_key      <= cfg_key;
            aes_key_mode <= cfg_key_mode;
            aes_ende     <= cfg_ende;
            aes_start    <= 1'b1;
            state        <= ST_KSTART;
          end
        end
        ST_KSTART: begin
          // a reload during the start pulse restarts expansion via the drain path
          if (cfg_load) begin
            state <= ST_DRAIN;
          end else begin
            kw_first <= 1'b1;
            state    <= ST_KWAIT;
          end
        end
        ST_KWAIT: begin
          if (cfg_load) begin
            state <= ST_DRAIN;
          end else if (kw_first) begin
            kw_first <= 1'b0;
          end else if (aes_key_ready) begin
            key_ok <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cfg_load) begin
            key_ok <= 1'b0;
            state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          key_ok <= 1'b0;
          if (!outstanding) begin
            aes_key      <= cfg_load ? cfg_key      : sh_key;
            aes_key_mode <= cfg_load ? cfg_key_mode : sh_mode;
            aes_ende     <= cfg_load ? cfg_ende     : sh_ende;
            aes_start    <= 1'b1;
            state        <= ST_KSTART;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb/tb_aes_stream_ctrl.sv - scoreboard bench for aes_stream_ctrl with a behavioural core
module tb_aes_stream_ctrl;

  logic         clk;
  logic         reset;
  logic [255:0] cfg_key;
  logic [1:0]   cfg_key_mode;
  logic         cfg_ende;
  logic         cfg_load;
  logic [127:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         aes_start;
  logic         aes_enable;
  logic         aes_ende;
  logic [1:0]   aes_key_mode;
  logic [255:0] aes_key;
  logic [127:0] aes_data;
  logic         aes_data_valid;
  logic         aes_ready;
  logic [127:0] aes_out_data;
  logic         aes_out_valid;
  logic         aes_key_ready;
  logic         key_ok;
  logic         err_overflow;

  aes_stream_ctrl #(.IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cfg_key(cfg_key), .cfg_key_mode(cfg_key_mode), .cfg_ende(cfg_ende), .cfg_load(cfg_load),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .aes_start(aes_start), .aes_enable(aes_enable), .aes_ende(aes_ende),
    .aes_key_mode(aes_key_mode), .aes_key(aes_key),
    .aes_data(aes_data), .aes_data_valid(aes_data_valid), .aes_ready(aes_ready),
    .aes_out_data(aes_out_data), .aes_out_valid(aes_out_valid), .aes_key_ready(aes_key_ready),
    .key_ok(key_ok), .err_overflow(err_overflow)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [127:0] exp_q[$];

  logic [255:0] cur_key = '0;
  logic [1:0]   cur_mode = '0;
  logic         cur_ende = 1'b0;
  int           acc_cyc = 0;

  int   mr_mode = 1;
  logic core_stall = 1'b0;
  logic inj = 1'b0;
  int   issue_cnt = 0;
  int   start_cnt = 0;
  int   bad_start = 0;
  int   last_issue_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in cipher: reversible, sensitive to every key bit the mode selects and to ende.
  function automatic logic [127:0] fake_cipher(input logic [127:0] d, input logic [255:0] k,
                                               input logic [1:0] md, input logic e);
    logic [255:0] used;
    used = (md == 2'd0) ? {k[255:128], 128'b0} : (md == 2'd1) ? {k[255:64], 64'b0} : k;
    return d ^ used[255:128] ^ {used[63:0], used[127:64]} ^ {128{e}} ^ {126'b0, md};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_aes_start"}, aes_start, 0);
    check({tag, "_aes_enable"}, aes_enable, 0);
    check({tag, "_aes_ende"}, aes_ende, 0);
    check({tag, "_aes_key_mode"}, aes_key_mode, 0);
    check({tag, "_aes_key"}, aes_key, 0);
    check({tag, "_aes_data"}, aes_data, 0);
    check({tag, "_aes_data_valid"}, aes_data_valid, 0);
    check({tag, "_key_ok"}, key_ok, 0);
    check({tag, "_err_overflow"}, err_overflow, 0);
  endtask

  // downstream ready: 0 = stalled, 1 = always ready, 2 = random
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_ready = (mr_mode == 1) ? 1'b1 : (mr_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
    end
  end

  // behavioural core: key expansion delay, ready hold after issue, variable result latency
  initial begin
    automatic bit busy = 0;
    automatic int key_cnt = 0;
    automatic int hold = 0;
    automatic int lat = 0;
    automatic logic [127:0] res = '0;
    aes_ready = 1'b1; aes_key_ready = 1'b0; aes_out_valid = 1'b0; aes_out_data = '0;
    forever begin
      @(negedge clk);
      aes_out_valid = 1'b0;
      if (reset) begin
        busy = 0; key_cnt = 0; aes_key_ready = 1'b0; aes_ready = 1'b1;
        continue;
      end
      if (inj) begin
        aes_out_valid = 1'b1;
        aes_out_data = rand128();
      end
      if (aes_start) begin
        start_cnt++;
        if (busy) bad_start++;
        aes_key_ready = 1'b0;
        key_cnt = $urandom_range(2, 5);
      end else if (key_cnt > 0) begin
        key_cnt--;
        if (key_cnt == 0) aes_key_ready = 1'b1;
      end
      if (aes_data_valid) begin
        vectors++;
        if (busy || !aes_key_ready) begin
          miscompares++;
          $display("FAIL core_issue: busy=%0d key_ready=%0d required busy=0 key_ready=1", busy, aes_key_ready);
        end
        issue_cnt++;
        last_issue_cyc = cyc;
        busy = 1;
        res = fake_cipher(aes_data, aes_key, aes_key_mode, aes_ende);
        hold = $urandom_range(0, 3);
        lat = hold + $urandom_range(1, 3);
        if (hold == 0) aes_ready = 1'b0;
      end else if (busy) begin
        lat--;
        if (hold > 0) hold--;
        if (hold == 0) aes_ready = 1'b0;
        if (lat == 0) begin
          aes_out_valid = 1'b1;
          aes_out_data = res;
          busy = 0;
        end
      end
      if (core_stall) aes_ready = 1'b0;
      else if (!busy) aes_ready = 1'b1;
    end
  end

  // output monitor: every downstream transfer must match the oldest expected result
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && m_valid && m_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output: got %0h required no output", m_data);
        end else begin
          automatic logic [127:0] e = exp_q.pop_front();
          if (m_data !== e) begin
            miscompares++;
            $display("FAIL m_data: got %0h expected %0h", m_data, e);
          end
        end
      end
    end
  end

  task automatic push_block(input logic [127:0] d);
    automatic int t = 0;
    s_data = d;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 300) break;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (t > 300) begin
      check("push_timeout", 1, 0);
    end else begin
      acc_cyc = cyc;
      exp_q.push_back(fake_cipher(d, cur_key, cur_mode, cur_ende));
    end
  endtask

  task automatic load_cfg(input logic [255:0] k, input logic [1:0] md, input logic e);
    cfg_key = k; cfg_key_mode = md; cfg_ende = e; cfg_load = 1'b1;
    cur_key = k; cur_mode = md; cur_ende = e;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic wait_key_ok();
    automatic int t = 0;
    while (!key_ok && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("key_ok_timeout", key_ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    automatic int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic wait_issue(input int base);
    automatic int t = 0;
    while (issue_cnt == base && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("issue_timeout", issue_cnt > base, 1);
  endtask

  initial begin
    automatic int base = 0;
    automatic int sbase = 0;
    reset = 1'b1; s_valid = 1'b0; s_data = '0;
    cfg_key = '0; cfg_key_mode = '0; cfg_ende = 1'b0; cfg_load = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("aes_enable_after_reset", aes_enable, 1);
    check("key_ok_idle", key_ok, 0);

    // 128-bit encrypt, with a block already queued while idle
    cur_key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0}; cur_mode = 2'd0; cur_ende = 1'b0;
    push_block(128'h00112233445566778899aabbccddeeff);
    repeat (5) @(posedge clk); #1;
    check("idle_no_issue", issue_cnt, 0);
    load_cfg(cur_key, 2'd0, 1'b0);
    wait_key_ok();
    check("single_start", start_cnt, 1);
    mr_mode = 2;
    repeat (10) push_block(rand128());
    wait_drain();

    // decrypt under the same key; first block checks issue latency from an empty pipe
    mr_mode = 1;
    load_cfg(cur_key, 2'd0, 1'b1);
    wait_key_ok();
    base = issue_cnt;
    push_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_issue(base);
    check("issue_latency", last_issue_cyc - acc_cyc, 2);
    wait_drain();

    // 256-bit key
    load_cfg(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 2'd2, 1'b0);
    wait_key_ok();
    mr_mode = 2;
    push_block(128'h00112233445566778899aabbccddeeff);
    repeat (6) push_block(rand128());
    wait_drain();

    // downstream stalled: only OUT_DEPTH blocks may be issued
    mr_mode = 0;
    repeat (3) @(posedge clk); #1;
    base = issue_cnt;
    repeat (8) push_block(rand128());
    repeat (60) @(posedge clk); #1;
    check("stall_issues", issue_cnt - base, 4);
    check("stall_s_ready", s_ready, 0);
    check("stall_m_valid", m_valid, 1);
    check("stall_err", err_overflow, 0);
    mr_mode = 1;
    wait_drain();

    // reload with a block in flight: old key finishes first, start only after its result
    mr_mode = 2;
    base = issue_cnt;
    sbase = start_cnt;
    push_block(rand128());
    wait_issue(base);
    @(posedge clk); #1;
    load_cfg({rand128(), rand128()}, 2'd1, 1'b1);
    wait_key_ok();
    check("reload_start_count", start_cnt - sbase, 1);
    check("reload_start_while_busy", bad_start, 0);
    push_block(rand128());
    push_block(rand128());
    wait_drain();

    // unsolicited result is dropped and flagged
    check("err_before_spurious", err_overflow, 0);
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("err_after_spurious", err_overflow, 1);
    check("spurious_m_valid", m_valid, 0);

    // reset while running with queued blocks
    core_stall = 1'b1;
    repeat (3) @(posedge clk); #1;
    push_block(rand128());
    push_block(rand128());
    check("pre_reset_key_ok", key_ok, 1);
    reset = 1'b1;
    #1;
    check_reset_values("midrun");
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    core_stall = 1'b0;
    repeat (30) @(posedge clk); #1;
    check("post_reset_m_valid", m_valid, 0);
    check("post_reset_s_ready", s_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
